// File: rtl/coin_credit_acc_if.sv
// Coin/credit bus between the coin front end and the dispenser.
// master drives COIN_IN, CANCEL, SEL_VLD, SEL, DONE; slave drives the rest.
interface coin_credit_acc_if;
  logic       COIN_IN;
  logic       CANCEL;
  logic       SEL_VLD;
  logic [3:0] SEL;
  logic       DONE;
  logic [2:0] CIN;
  logic [3:0] SA;
  logic       E;
  logic       RET;
  logic       REJECT;
  logic       DENY;

  modport master (
    output COIN_IN, CANCEL, SEL_VLD, SEL, DONE,
    input  CIN, SA, E, RET, REJECT, DENY
  );

  modport slave (
    input  COIN_IN, CANCEL, SEL_VLD, SEL, DONE,
    output CIN, SA, E, RET, REJECT, DENY
  );
endinterface

// File: rtl/coin_credit_acc.sv
// Coin credit accumulator: debounced coins -> saturating credit, selection
// latch, vend enable and change payout. Ports: CLK, RESET_N, bus (slave).
module coin_credit_acc #(
  parameter int MAX_CREDIT = 7,
  parameter int DEB_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RESET_N,
  coin_credit_acc_if.slave   bus
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [2:0]    MAX_C    = 3'(MAX_CREDIT);

  typedef enum logic [1:0] {
    IDLE, CREDIT, VEND, CHANGE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          fired_q;
  logic [CW-1:0] deb_q;
  logic          coin_ev;
  logic [2:0]    cin_q, cin_d;
  logic [3:0]    sa_q, sa_d;
  logic          e_q, e_d;
  logic          ret_q, ret_d;
  logic          rej_q, rej_d;
  logic          deny_q, deny_d;
  logic [2:0]    price_sel, price_sa;

  // fired_q blocks further events until the synced input reads low
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      sync1_q <= bus.COIN_IN;
      sync2_q <= sync1_q;
      if (!sync2_q) begin
        deb_q   <= '0;
        fired_q <= 1'b0;
      end else if (!fired_q) begin
        if (deb_q == DEB_LAST) begin
          deb_q   <= '0;
          fired_q <= 1'b1;
        end else begin
          deb_q <= deb_q + CW'(1);
        end
      end
    end
  end

  assign coin_ev = sync2_q && !fired_q
                && (deb_q == DEB_LAST);

  assign price_sel = {1'b0, bus.SEL[1:0]} + 3'd1;
  assign price_sa  = {1'b0, sa_q[1:0]} + 3'd1;

  always_comb begin
    state_d = state_q;
    cin_d   = cin_q;
    sa_d    = sa_q;
    ret_d   = 1'b0;
    rej_d   = 1'b0;
    deny_d  = 1'b0;
    if (coin_ev) begin
      if ((state_q == IDLE || state_q == CREDIT)
          && cin_q < MAX_C)
        cin_d = cin_q + 3'd1;
      else
        rej_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (coin_ev) state_d = CREDIT;
        if (bus.SEL_VLD) deny_d = 1'b1;
      end
      CREDIT: begin
        if (bus.CANCEL) begin
          state_d = CHANGE;
        end else if (bus.SEL_VLD) begin
          // compare against pre-coin credit
          if (price_sel <= cin_q) begin
            sa_d    = bus.SEL;
            state_d = VEND;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      VEND: begin
        if (bus.DONE) begin
          cin_d   = cin_q - price_sa;
          state_d = (cin_q == price_sa) ? IDLE : CHANGE;
        end
      end
      CHANGE: begin
        if (ret_q) begin
          if (cin_q == 3'd0) state_d = IDLE;
        end else begin
          ret_d = 1'b1;
          cin_d = cin_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    e_d = (state_d == VEND);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cin_q   <= '0;
      sa_q    <= '0;
      e_q     <= 1'b0;
      ret_q   <= 1'b0;
      rej_q   <= 1'b0;
      deny_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cin_q   <= cin_d;
      sa_q    <= sa_d;
      e_q     <= e_d;
      ret_q   <= ret_d;
      rej_q   <= rej_d;
      deny_q  <= deny_d;
    end
  end

  assign bus.CIN    = cin_q;
  assign bus.SA     = sa_q;
  assign bus.E      = e_q;
  assign bus.RET    = ret_q;
  assign bus.REJECT = rej_q;
  assign bus.DENY   = deny_q;

endmodule

// File: tb/tb_coin_credit_acc.sv
// Scoreboard bench for coin_credit_acc: expected output events are queued
// with each stimulus and matched in order against observed events.
module tb_coin_credit_acc;

  localparam int DEB = 4;
  localparam int EV_CIN  = 1;
  localparam int EV_E    = 2;
  localparam int EV_RET  = 3;
  localparam int EV_REJ  = 4;
  localparam int EV_DENY = 5;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   cyc;
  int   ret_last;
  bit   ret_seen;
  bit   mon_en;
  logic [2:0] cin_prev;
  logic       e_prev;
  logic [31:0] exp_q[$];

  coin_credit_acc_if bus();

  coin_credit_acc #(
    .MAX_CREDIT(7),
    .DEB_CYCLES(DEB)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ex(input int k, input int v);
    exp_q.push_back(32'(k * 256 + v));
  endtask

  task automatic obs(input int k, input int v);
    logic [31:0] ev;
    ev = 32'(k * 256 + v);
    if (exp_q.size() == 0)
      chk("sb_extra", ev, 32'hFFFF_FFFF);
    else
      chk("sb", ev, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (bus.REJECT) obs(EV_REJ, 0);
      if (bus.DENY) obs(EV_DENY, 0);
      if (bus.RET) begin
        obs(EV_RET, 0);
        if (ret_seen) chk("ret_gap", 32'(cyc - ret_last), 2);
        ret_last = cyc;
        ret_seen = 1'b1;
      end
      if (bus.CIN != cin_prev) obs(EV_CIN, int'(bus.CIN));
      if (bus.E != e_prev) obs(EV_E, int'(bus.E));
    end
    cin_prev = bus.CIN;
    e_prev   = bus.E;
  end

  task automatic coin();
    @(negedge clk) bus.COIN_IN = 1'b1;
    repeat (DEB + 1) @(negedge clk);
    bus.COIN_IN = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic sel(input logic [3:0] v);
    @(negedge clk);
    bus.SEL_VLD = 1'b1;
    bus.SEL     = v;
    @(negedge clk);
    bus.SEL_VLD = 1'b0;
  endtask

  task automatic done();
    ret_seen = 1'b0;
    @(negedge clk) bus.DONE = 1'b1;
    @(negedge clk) bus.DONE = 1'b0;
  endtask

  task automatic drain(input int lim);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk("drain", 32'(exp_q.size()), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    ret_last = 0;
    ret_seen = 1'b0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    bus.COIN_IN = 1'b0;
    bus.CANCEL  = 1'b0;
    bus.SEL_VLD = 1'b0;
    bus.SEL     = 4'd0;
    bus.DONE    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cin", 32'(bus.CIN), 0);
    chk("rst_sa", 32'(bus.SA), 0);
    chk("rst_e", 32'(bus.E), 0);
    chk("rst_ret", 32'(bus.RET), 0);
    chk("rst_rej", 32'(bus.REJECT), 0);
    chk("rst_deny", 32'(bus.DENY), 0);
    mon_en = 1'b1;

    // 1: short glitch never qualifies
    @(negedge clk) bus.COIN_IN = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    bus.COIN_IN = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_cin", 32'(bus.CIN), 0);

    // 2: exact-price vend
    ex(EV_CIN, 1); ex(EV_CIN, 2); ex(EV_CIN, 3);
    repeat (3) coin();
    ex(EV_E, 1);
    sel(4'b0010);
    drain(20);
    chk("t2_sa", 32'(bus.SA), 2);
    ex(EV_CIN, 0); ex(EV_E, 0);
    done();
    drain(20);

    // 3: vend with three change pulses
    for (int i = 1; i <= 5; i++) begin
      ex(EV_CIN, i);
      coin();
    end
    ex(EV_E, 1);
    sel(4'b0001);
    drain(20);
    chk("t3_sa", 32'(bus.SA), 1);
    ex(EV_CIN, 3); ex(EV_E, 0);
    for (int i = 2; i >= 0; i--) begin
      ex(EV_RET, 0); ex(EV_CIN, i);
    end
    done();
    drain(40);

    // 4: saturation, then cancel beats select
    for (int i = 1; i <= 7; i++) begin
      ex(EV_CIN, i);
      coin();
    end
    ex(EV_REJ, 0);
    coin();
    drain(20);
    chk("t4_cin", 32'(bus.CIN), 7);
    for (int i = 6; i >= 0; i--) begin
      ex(EV_RET, 0); ex(EV_CIN, i);
    end
    ret_seen = 1'b0;
    @(negedge clk);
    bus.CANCEL  = 1'b1;
    bus.SEL_VLD = 1'b1;
    bus.SEL     = 4'b0000;
    @(negedge clk);
    bus.CANCEL  = 1'b0;
    bus.SEL_VLD = 1'b0;
    drain(60);
    chk("t4_sa", 32'(bus.SA), 1);

    // 5: deny, then vend with a rejected coin
    ex(EV_CIN, 1);
    coin();
    ex(EV_DENY, 0);
    sel(4'b0011);
    drain(20);
    chk("t5_cin", 32'(bus.CIN), 1);
    ex(EV_E, 1);
    sel(4'b0000);
    drain(20);
    chk("t5_sa", 32'(bus.SA), 0);
    ex(EV_REJ, 0);
    coin();
    drain(20);
    chk("t5_cin2", 32'(bus.CIN), 1);
    ex(EV_CIN, 0); ex(EV_E, 0);
    done();
    drain(20);

    // 6a: reset during VEND
    ex(EV_CIN, 1); ex(EV_CIN, 2);
    coin(); coin();
    ex(EV_E, 1);
    sel(4'b0100);
    drain(20);
    chk("t6_sa_pre", 32'(bus.SA), 4);
    mon_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6v_cin", 32'(bus.CIN), 0);
    chk("t6v_e", 32'(bus.E), 0);
    chk("t6v_sa", 32'(bus.SA), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) mon_en = 1'b1;

    // 6b: reset during CHANGE
    ex(EV_CIN, 1); ex(EV_CIN, 2); ex(EV_CIN, 3);
    repeat (3) coin();
    ex(EV_RET, 0); ex(EV_CIN, 2);
    ret_seen = 1'b0;
    @(negedge clk) bus.CANCEL = 1'b1;
    @(negedge clk) bus.CANCEL = 1'b0;
    while (exp_q.size() != 0) @(negedge clk);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t6c_cin", 32'(bus.CIN), 0);
    chk("t6c_ret", 32'(bus.RET), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) mon_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_cin", 32'(bus.CIN), 0);
    ex(EV_CIN, 1);
    coin();
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
